// File: rtl/gpr_pkg.sv
// Shared register-file definitions: default data width and word type.
package gpr_pkg;
   localparam int DATA_W = 32;
   typedef logic [DATA_W-1:0] data_t;
endpackage

// File: rtl/mux_2_32bit_if.sv
// Bundle of select/bypass data, control and observation signals.
// master drives data/select/clear; slave is the mux block.
interface mux_2_32bit_if
   import gpr_pkg::*;
#(
   parameter int WIDTH = DATA_W,
   parameter int CNT_W = 16
);
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             op;
   logic             cnt_clr;
   logic [WIDTH-1:0] sel;
   logic [WIDTH-1:0] sel_q;
   logic             op_q;
   logic [CNT_W-1:0] bypass_cnt;

   modport master (
      output a, b, op, cnt_clr,
      input  sel, sel_q, op_q, bypass_cnt
   );

   modport slave (
      input  a, b, op, cnt_clr,
      output sel, sel_q, op_q, bypass_cnt
   );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear beats increment).
// Latency: 1 cycle; no backpressure, holds at all-ones instead of wrapping.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt
);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && (cnt != {W{1'b1}})) begin
         cnt <= cnt + W'(1);
      end
   end
endmodule

// File: rtl/mux_2_32bit.sv
// Read-port write-through select: sel is combinational (0 cycles), sel_q/op_q
// and bypass_cnt are 1-cycle registered; no handshake, every cycle is valid.
module mux_2_32bit
   import gpr_pkg::*;
#(
   parameter int WIDTH = DATA_W,
   parameter int CNT_W = 16
) (
   input  logic          clk,
   input  logic          reset,
   mux_2_32bit_if.slave  bus
);
   logic [WIDTH-1:0] sel_c;
   logic [WIDTH-1:0] sel_r;
   logic             op_r;

   // sel is deliberately outside the reset domain so the read port stays live.
   always_comb begin
      sel_c = bus.op ? bus.b : bus.a;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sel_r <= '0;
         op_r  <= 1'b0;
      end else begin
         sel_r <= sel_c;
         op_r  <= bus.op;
      end
   end

   assign bus.sel   = sel_c;
   assign bus.sel_q = sel_r;
   assign bus.op_q  = op_r;

   sat_counter #(
      .W (CNT_W)
   ) u_bypass_cnt (
      .clk   (clk),
      .rst_n (reset),
      .clr   (bus.cnt_clr),
      .inc   (bus.op),
      .cnt   (bus.bypass_cnt)
   );
endmodule

// File: tb/tb_mux_2_32bit.sv
// Self-checking bench for mux_2_32bit: vector table, staging, counter, reset, random.
module tb_mux_2_32bit;
   import gpr_pkg::*;

   typedef struct {
      data_t a;
      data_t b;
      logic  op;
      data_t exp_sel;
   } vec_t;

   typedef struct {
      data_t sel;
      logic  op;
   } stage_t;

   logic clk;
   logic reset;
   int   total;
   int   bad;

   mux_2_32bit_if #(.WIDTH(32), .CNT_W(16)) bus  ();
   mux_2_32bit_if #(.WIDTH(32), .CNT_W(4))  bus4 ();

   mux_2_32bit #(.WIDTH(32), .CNT_W(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   mux_2_32bit #(.WIDTH(32), .CNT_W(4)) dut4 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus4.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%h exp=%h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   vec_t   vecs[6];
   stage_t sb[$];

   initial begin
      stage_t s;
      data_t  ra, rb;
      logic   rop;
      total = 0;
      bad   = 0;

      vecs[0] = '{32'h1234_5678, 32'hDEAD_BEEF, 1'b0, 32'h1234_5678};
      vecs[1] = '{32'h1234_5678, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF};
      vecs[2] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 32'hFFFF_FFFF};
      vecs[3] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000};
      vecs[4] = '{32'h5555_AAAA, 32'hAAAA_5555, 1'b1, 32'hAAAA_5555};
      vecs[5] = '{32'h5555_AAAA, 32'hAAAA_5555, 1'b0, 32'h5555_AAAA};

      reset = 1'b0;
      bus.a = '0; bus.b = '0; bus.op = 1'b0; bus.cnt_clr = 1'b0;
      bus4.a = '0; bus4.b = '0; bus4.op = 1'b0; bus4.cnt_clr = 1'b0;
      #3;
      chk("rst_sel_q", bus.sel_q, 32'h0);
      chk("rst_op_q", {31'b0, bus.op_q}, 32'h0);
      chk("rst_cnt", {16'b0, bus.bypass_cnt}, 32'h0);
      chk("rst_cnt4", {28'b0, bus4.bypass_cnt}, 32'h0);
      @(negedge clk);
      reset = 1'b1;

      // table: all vectors applied within one clock period, no edge in between
      step();
      for (int i = 0; i < 6; i++) begin
         bus.a = vecs[i].a; bus.b = vecs[i].b; bus.op = vecs[i].op;
         #1;
         chk($sformatf("vec%0d_sel", i), bus.sel, vecs[i].exp_sel);
      end

      // registered stage
      bus.a = 32'h1111_1111; bus.b = 32'h0; bus.op = 1'b0;
      step();
      bus.op = 1'b1; bus.b = 32'hA5A5_A5A5;
      #1;
      chk("stage_pre_sel_q", bus.sel_q, 32'h1111_1111);
      chk("stage_pre_op_q", {31'b0, bus.op_q}, 32'h0);
      step();
      chk("stage_sel_q", bus.sel_q, 32'hA5A5_A5A5);
      chk("stage_op_q", {31'b0, bus.op_q}, 32'h1);

      // counter: clear, 5 counted cycles, 3 idle
      bus.op = 1'b0; bus.cnt_clr = 1'b1;
      step();
      bus.cnt_clr = 1'b0;
      chk("cnt_clear", {16'b0, bus.bypass_cnt}, 32'h0);
      bus.op = 1'b1;
      for (int i = 0; i < 5; i++) step();
      bus.op = 1'b0;
      for (int i = 0; i < 3; i++) step();
      chk("cnt_five", {16'b0, bus.bypass_cnt}, 32'd5);
      bus.op = 1'b1; bus.cnt_clr = 1'b1;
      step();
      chk("cnt_clr_wins", {16'b0, bus.bypass_cnt}, 32'h0);
      bus.cnt_clr = 1'b0;
      step();
      chk("cnt_after_clr", {16'b0, bus.bypass_cnt}, 32'd1);
      bus.op = 1'b0;

      // saturation on the 4-bit counter
      bus4.op = 1'b1;
      for (int i = 0; i < 14; i++) step();
      chk("sat_14", {28'b0, bus4.bypass_cnt}, 32'd14);
      for (int i = 0; i < 6; i++) step();
      chk("sat_20", {28'b0, bus4.bypass_cnt}, 32'd15);
      step();
      chk("sat_hold", {28'b0, bus4.bypass_cnt}, 32'd15);
      bus4.op = 1'b0;

      // async reset between edges
      bus.a = 32'hCAFE_F00D; bus.op = 1'b0;
      step();
      chk("pre_rst_sel_q", bus.sel_q, 32'hCAFE_F00D);
      #2;
      reset = 1'b0;
      #1;
      chk("arst_sel_q", bus.sel_q, 32'h0);
      chk("arst_op_q", {31'b0, bus.op_q}, 32'h0);
      chk("arst_cnt", {16'b0, bus.bypass_cnt}, 32'h0);
      chk("arst_cnt4", {28'b0, bus4.bypass_cnt}, 32'h0);
      chk("arst_sel_a", bus.sel, 32'hCAFE_F00D);
      bus.b = 32'h0BAD_CAFE; bus.op = 1'b1;
      #1;
      chk("arst_sel_b", bus.sel, 32'h0BAD_CAFE);
      step();
      chk("arst_hold_sel_q", bus.sel_q, 32'h0);
      @(negedge clk);
      reset = 1'b1;
      bus.op = 1'b0;

      // random with one-cycle scoreboard on sel_q/op_q
      step();
      for (int i = 0; i < 1000; i++) begin
         if (sb.size() > 0) begin
            s = sb.pop_front();
            chk("rnd_sel_q", bus.sel_q, s.sel);
            chk("rnd_op_q", {31'b0, bus.op_q}, {31'b0, s.op});
         end
         ra  = $urandom;
         rb  = $urandom;
         rop = 1'($urandom_range(0, 1));
         bus.a = ra; bus.b = rb; bus.op = rop;
         #1;
         s.sel = rop ? rb : ra;
         s.op  = rop;
         chk("rnd_sel", bus.sel, s.sel);
         sb.push_back(s);
         step();
      end
      if (sb.size() > 0) begin
         s = sb.pop_front();
         chk("rnd_sel_q_last", bus.sel_q, s.sel);
         chk("rnd_op_q_last", {31'b0, bus.op_q}, {31'b0, s.op});
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
